// File: rtl/risc16_pkg.sv
// Shared types for the 16-bit RISC pipeline: instruction word layout,
// fetch-stage state encoding and common constants.
package risc16;

  localparam int PC_WIDTH = 16;

  // All-zero word decodes as OP_NOP in the decode stage.
  typedef struct packed {
    logic [3:0] opcode;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [5:0] imm;
  } inst_t;

  localparam inst_t INSTR_NOP = '0;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } if_state_t;

endpackage

// File: rtl/stage_if_skid.sv
// One-entry {instr, pc} holding register used by the fetch stage to park the
// response that lands while decode is stalled.
module if_skid_reg
  import risc16::*;
#(
  parameter int PC_WIDTH = risc16::PC_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic                drain_i,
  input  logic                clear_i,
  input  inst_t               instr_i,
  input  logic [PC_WIDTH-1:0] pc_i,
  output inst_t               instr_o,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic                full_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_o  <= 1'b0;
      instr_o <= INSTR_NOP;
      pc_o    <= '0;
    end else if (clear_i) begin
      full_o  <= 1'b0;
    end else if (load_i) begin
      full_o  <= 1'b1;
      instr_o <= instr_i;
      pc_o    <= pc_i;
    end else if (drain_i) begin
      full_o  <= 1'b0;
    end
  end

endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle synchronous imem and
// registers one instruction per cycle toward decode, with stall skid and
// redirect flush. Optional perf counters: RISC16_IF_PERF_CNT_EN.
module stage_if
  import risc16::*;
#(
  parameter int                  PC_WIDTH = risc16::PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                stall_i,
  input  logic                redirect_valid_i,
  input  logic [PC_WIDTH-1:0] redirect_pc_i,
  output logic                imem_rd_en_o,
  output logic [PC_WIDTH-1:0] imem_addr_o,
  input  logic [15:0]         imem_rdata_i,
  output inst_t               instr_o,
  output logic                instr_valid_o,
`ifdef RISC16_IF_PERF_CNT_EN
  output logic [PC_WIDTH-1:0] pc_o,
  output logic [31:0]         perf_fetch_cnt_o,
  output logic [31:0]         perf_stall_cnt_o
`else
  output logic [PC_WIDTH-1:0] pc_o
`endif
);

  if_state_t           state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q;
  logic                inflight_q;
  logic [PC_WIDTH-1:0] inflight_pc_q;

  logic                fetch;
  logic                resp;

  inst_t               instr_d;
  logic                valid_d;
  logic [PC_WIDTH-1:0] pc_out_d;

  logic                skid_load, skid_drain, skid_full;
  inst_t               skid_instr;
  logic [PC_WIDTH-1:0] skid_pc;

  assign fetch        = (state_q != BOOT) && !stall_i && !redirect_valid_i;
  // FLUSH is the cycle after a redirect; anything landing then belongs to the old stream.
  assign resp         = inflight_q && (state_q != FLUSH);
  assign imem_rd_en_o = fetch;
  assign imem_addr_o  = pc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      FLUSH:   state_d = RUN;
      default: state_d = BOOT;
    endcase
    if (redirect_valid_i) begin
      state_d = FLUSH;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      inflight_q <= fetch;
      if (redirect_valid_i) begin
        pc_q <= redirect_pc_i;
      end else if (fetch) begin
        pc_q          <= pc_q + 1'b1;
        inflight_pc_q <= pc_q;
      end
    end
  end

  assign skid_load  = stall_i && !redirect_valid_i && resp;
  assign skid_drain = skid_full && !stall_i && !redirect_valid_i;

  if_skid_reg #(
    .PC_WIDTH(PC_WIDTH)
  ) u_skid (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (skid_load),
    .drain_i(skid_drain),
    .clear_i(redirect_valid_i),
    .instr_i(inst_t'(imem_rdata_i)),
    .pc_i   (inflight_pc_q),
    .instr_o(skid_instr),
    .pc_o   (skid_pc),
    .full_o (skid_full)
  );

  always_comb begin
    instr_d  = INSTR_NOP;
    valid_d  = 1'b0;
    pc_out_d = '0;
    if (redirect_valid_i) begin
      instr_d  = INSTR_NOP;
    end else if (stall_i) begin
      instr_d  = instr_o;
      valid_d  = instr_valid_o;
      pc_out_d = pc_o;
    end else if (skid_full) begin
      instr_d  = skid_instr;
      valid_d  = 1'b1;
      pc_out_d = skid_pc;
    end else if (resp) begin
      instr_d  = inst_t'(imem_rdata_i);
      valid_d  = 1'b1;
      pc_out_d = inflight_pc_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_o       <= INSTR_NOP;
      instr_valid_o <= 1'b0;
      pc_o          <= '0;
    end else begin
      instr_o       <= instr_d;
      instr_valid_o <= valid_d;
      pc_o          <= pc_out_d;
    end
  end

  // A response only follows an unstalled cycle, and that cycle drained the skid.
  skid_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
    !(skid_full && resp));

`ifdef RISC16_IF_PERF_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_fetch_cnt_o <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (fetch && (perf_fetch_cnt_o != 32'hFFFF_FFFF)) begin
        perf_fetch_cnt_o <= perf_fetch_cnt_o + 32'd1;
      end
      if (stall_i && (perf_stall_cnt_o != 32'hFFFF_FFFF)) begin
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: directed and random stall/redirect traffic against a
// transaction-level fetch model, plus a second instance started at 0xFFFE.
module tb_stage_if;
  import risc16::*;

  localparam logic [15:0] KEY = 16'h5A3C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        stall, redir;
  logic [15:0] rpc;
  logic        rd_en, valid;
  logic [15:0] addr, rdata, pc;
  inst_t       instr;

  logic        rd_en2, valid2;
  logic [15:0] addr2, rdata2, pc2;
  inst_t       instr2;

`ifdef RISC16_IF_PERF_CNT_EN
  logic [31:0] pf, ps, pf2, ps2;
`endif

  stage_if dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .stall_i         (stall),
    .redirect_valid_i(redir),
    .redirect_pc_i   (rpc),
    .imem_rd_en_o    (rd_en),
    .imem_addr_o     (addr),
    .imem_rdata_i    (rdata),
    .instr_o         (instr),
    .instr_valid_o   (valid),
`ifdef RISC16_IF_PERF_CNT_EN
    .pc_o            (pc),
    .perf_fetch_cnt_o(pf),
    .perf_stall_cnt_o(ps)
`else
    .pc_o            (pc)
`endif
  );

  stage_if #(.PC_WIDTH(16), .RESET_PC(16'hFFFE)) dut2 (
    .clk_i           (clk),
    .rst_i           (rst),
    .stall_i         (1'b0),
    .redirect_valid_i(1'b0),
    .redirect_pc_i   (16'h0000),
    .imem_rd_en_o    (rd_en2),
    .imem_addr_o     (addr2),
    .imem_rdata_i    (rdata2),
    .instr_o         (instr2),
    .instr_valid_o   (valid2),
`ifdef RISC16_IF_PERF_CNT_EN
    .pc_o            (pc2),
    .perf_fetch_cnt_o(pf2),
    .perf_stall_cnt_o(ps2)
`else
    .pc_o            (pc2)
`endif
  );

  // Synchronous imem: word is a keyed function of its address.
  always @(posedge clk) begin
    if (rd_en)  rdata  <= addr  ^ KEY;
    if (rd_en2) rdata2 <= addr2 ^ KEY;
  end

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] ins;
    logic [15:0] pc;
  } entry_t;

  bit          m_booted;
  logic [15:0] m_pc;
  logic [15:0] pend_q[$];
  entry_t      skid_q[$];
  logic [15:0] m_ins, m_opc;
  logic        m_val;
  longint      m_fetches, m_stalls;
  int          cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_booted  = 1'b0;
    m_pc      = 16'h0000;
    pend_q.delete();
    skid_q.delete();
    m_ins     = '0;
    m_opc     = '0;
    m_val     = 1'b0;
    m_fetches = 0;
    m_stalls  = 0;
    cyc       = 0;
  endtask

  // Entered at a negedge; leaves at the next negedge.
  task automatic step(input bit s, input bit r, input logic [15:0] t);
    bit          fetch, have_resp;
    logic [15:0] raddr;
    logic [15:0] e2;
    entry_t      e;

    chk("instr_o", instr, m_ins);
    chk("instr_valid_o", valid, m_val);
    chk("pc_o", pc, m_opc);
`ifdef RISC16_IF_PERF_CNT_EN
    chk("perf_fetch", pf, 32'(m_fetches));
    chk("perf_stall", ps, 32'(m_stalls));
`endif
    e2 = 16'hFFFE + 16'(cyc - 3);
    chk("wrap_valid", valid2, (cyc >= 3));
    chk("wrap_pc", pc2, (cyc >= 3) ? e2 : 16'h0000);
    chk("wrap_instr", instr2, (cyc >= 3) ? (e2 ^ KEY) : 16'h0000);

    stall = s;
    redir = r;
    rpc   = t;
    #1;
    fetch = m_booted && !s && !r;
    chk("imem_rd_en", rd_en, fetch);
    chk("imem_addr", addr, m_pc);

    have_resp = (pend_q.size() > 0);
    raddr     = have_resp ? pend_q.pop_front() : 16'h0000;
    if (r) begin
      m_ins = '0; m_val = 1'b0; m_opc = '0;
      skid_q.delete();
      pend_q.delete();
    end else if (s) begin
      if (have_resp) skid_q.push_back('{raddr ^ KEY, raddr});
    end else if (skid_q.size() > 0) begin
      e = skid_q.pop_front();
      m_ins = e.ins; m_opc = e.pc; m_val = 1'b1;
    end else if (have_resp) begin
      m_ins = raddr ^ KEY; m_opc = raddr; m_val = 1'b1;
    end else begin
      m_ins = '0; m_val = 1'b0; m_opc = '0;
    end
    if (fetch) begin
      pend_q.push_back(m_pc);
      m_pc = m_pc + 16'd1;
      m_fetches++;
    end
    if (r) m_pc = t;
    if (s) m_stalls++;
    m_booted = 1'b1;
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    stall = 1'b0;
    redir = 1'b0;
    rpc   = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_instr", instr, 32'h0);
    chk("reset_valid", valid, 32'h0);
    chk("reset_pc", pc, 32'h0);
    chk("reset_addr", addr, 32'h0);
    rst = 1'b0;

    // free run, then a 3-cycle stall with a fetch in flight
    repeat (8) step(1'b0, 1'b0, 16'h0);
    repeat (3) step(1'b1, 1'b0, 16'h0);
    repeat (4) step(1'b0, 1'b0, 16'h0);

    // redirect while the stream is flowing
    step(1'b0, 1'b1, 16'h0040);
    repeat (5) step(1'b0, 1'b0, 16'h0);

    // redirect together with stall while the skid holds a word
    step(1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 16'h0100);
    step(1'b1, 1'b0, 16'h0);
    repeat (4) step(1'b0, 1'b0, 16'h0);

    // redirect to the top of the address space to exercise wrap
    step(1'b0, 1'b1, 16'hFFFD);
    repeat (6) step(1'b0, 1'b0, 16'h0);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0), 16'($urandom));
    end

    // asynchronous reset mid-stream with the skid full
    step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b0, 16'h0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_instr", instr, 32'h0);
    chk("async_rst_valid", valid, 32'h0);
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_addr", addr, 32'h0);
    chk("async_rst_rd_en", rd_en, 32'h0);
    stall = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) step(1'b0, 1'b0, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
